spi_bram_xfer_ctrl: RTL and testbench
=====================================

# spi_bram_xfer_ctrl

Parametrised command-driven bridge between an SPI slave byte interface and a multi-channel block RAM, fully synchronous to the system clock. It decodes a command byte and a 6-byte header (start address, length). It then streams N bytes into or out of the selected BRAM channel, returns an 8-bit checksum, reports sticky error status, and aborts cleanly on chip-select release. It sits between the SPI slave shifter and the frame-buffer BRAM bank.

## Interface
- ADDR_W, 17, BRAM address width (≤ 24)
- NUM_CH, 4, number of BRAM channels (≤ 64)
- CH_W, 2, width of mem_ch (clog2(NUM_CH), min 1)
- MEM_DEPTH, 76800, valid addresses per channel, 0..MEM_DEPTH-1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cs_n  in  1  SPI chip select, synchronised to clk, active-low
- byte_valid  in  1  one-clk pulse: rx_byte received, tx_byte consumed
- rx_byte  in  8  byte from master, valid with byte_valid
- tx_byte  out  8  byte shifted out on the next SPI exchange
- mem_addr  out  ADDR_W  BRAM address
- mem_ch  out  CH_W  BRAM channel select
- mem_we  out  1  BRAM write enable, one-cycle pulse
- mem_wdata  out  8  BRAM write data
- mem_rdata  in  8  BRAM read data, 1-cycle registered latency
- busy  out  1  high whenever state ≠ IDLE
- state  out  3  current FSM state code

## Operation
- Reset values: tx_byte=0x00, mem_addr=0, mem_ch=0, mem_we=0, mem_wdata=0, busy=0, state=IDLE. Checksum, counters and error flags are cleared.
- States: IDLE=0, HDR=1, WDATA=2, RFETCH=3, RDATA=4. Codes 5–7 are illegal and go to IDLE on the next clk.
- Command byte, accepted in IDLE: [7:6] op, [5:0] channel.
  - op 00 NOP: stay in IDLE.
  - op 11 STATUS: tx_byte <= {5'b0, err_abort, err_chan, err_range}, then all three flags clear. Stay in IDLE.
  - op 01 WRITE / op 10 READ: if channel ≥ NUM_CH, set err_chan and stay in IDLE. Otherwise latch mem_ch, clear checksum, hdr_cnt=6, go to HDR.
- HDR: six bytes, big-endian: start[23:0], then len[23:0]. On the 6th byte:
  - If start+len > MEM_DEPTH (25-bit compare), set err_range and go to IDLE with no memory access.
  - Else if len=0, tx_byte <= 0x00 and go to IDLE.
  - Else mem_addr <= start[ADDR_W-1:0], remaining=len, and go to WDATA (write) or RFETCH (read).
- WDATA: each byte_valid does mem_wdata <= rx_byte, mem_we=1 for exactly one cycle at the current mem_addr, and checksum += rx_byte (mod 256). mem_addr increments the cycle after the write. When remaining reaches 0, tx_byte <= final checksum and go to IDLE.
- RFETCH: wait one cycle for mem_rdata, then tx_byte <= mem_rdata, checksum += mem_rdata, mem_addr++, go to RDATA.
- RDATA: each byte_valid decrements remaining.
  - If remaining is nonzero, go to RFETCH.
  - Else tx_byte <= checksum and go to IDLE.
  - rx_byte is ignored during RDATA.
- Checksum covers data bytes only.
- cs_n high in any state other than IDLE aborts: err_abort=1, mem_we forced 0, go to IDLE, tx_byte <= 0x00. cs_n high in IDLE has no effect.
- Error flags are sticky. They clear only on STATUS or reset.
- mem_we is never asserted outside WDATA. No write ever targets an address ≥ MEM_DEPTH.

## Timing
- byte_valid sampled at edge E. All state and output updates occur at E unless stated otherwise.
- Write: mem_we high during the cycle after E, with mem_addr and mem_wdata stable.
- Read prefetch: mem_addr is driven at E, mem_rdata is valid at E+1, and tx_byte is updated at E+2.
- Upstream guarantees at least 3 clk between byte_valid pulses. tx_byte is therefore always stable before the next exchange starts.
- Final checksum: tx_byte updates at the E of the last data byte (write) or last exchange (read). The master clocks it out during the following command-byte exchange.
- If cs_n high and byte_valid occur in the same cycle, abort wins and the byte is discarded.
- Asynchronous reset mid-transfer: outputs go to reset values immediately, and mem_we drops without waiting for clk.

## Test plan
- WRITE ch2, start 0x000010, len 4, data 01 02 03 04 -> four mem_we pulses at addresses 0x10–0x13 on mem_ch=2; then tx_byte=0x0A, state=IDLE.
- READ ch2, start 0x10, len 4, with BRAM preloaded from the previous test -> tx_byte sequence 01,02,03,04, then 0x0A. No mem_we asserted.
- WRITE ch0, start 76798, len 3 -> err_range set, zero mem_we. STATUS then gives tx_byte=0x01, and a second STATUS gives 0x00.
- Command 0x45 (WRITE, channel 5) with NUM_CH=4 -> stays IDLE, err_chan set. STATUS gives 0x02.
- WRITE len 8: cs_n goes high after 3 data bytes -> exactly 3 writes, state IDLE, tx_byte=0x00, STATUS gives 0x04. A following full command executes normally.
- rst low during RDATA of a len-100 read -> all outputs at reset values. A new READ issued after release returns correct data from its own start address.

Source files
------------

// File: rtl/spi_bram_xfer_ctrl.sv
// spi_bram_xfer_ctrl: command-driven bridge between an SPI slave byte
// interface and a multi-channel block RAM. The command byte selects the
// operation and channel. A 6-byte big-endian header supplies start and
// length. Data bytes then stream to or from the BRAM, and a running 8-bit
// checksum is returned. Error status is sticky and is read back with STATUS.
// The bridge aborts cleanly if chip select is released mid-command.
module spi_bram_xfer_ctrl #(
   parameter int unsigned ADDR_W    = 17,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CH_W      = 2,
   parameter int unsigned MEM_DEPTH = 76800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              byte_valid,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [CH_W-1:0]   mem_ch,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic [2:0]        state
);

   localparam int unsigned HDR_BYTES = 6;
   localparam int unsigned LEN_W     = 24;
   localparam int unsigned SUM_W     = 25;
   localparam int unsigned CHK_W     = 7;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_READ   = 2'b10;
   localparam logic [1:0] OP_STATUS = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_WDATA  = 3'd2,
      ST_RFETCH = 3'd3,
      ST_RDATA  = 3'd4
   } state_e;

   state_e              state_q;
   logic                busy_q;
   logic [7:0]          tx_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CH_W-1:0]     ch_q;
   logic                we_q;
   logic [7:0]          wdata_q;

   logic                is_write_q;     // latched op: 1 = WRITE, 0 = READ
   logic [2:0]          hdr_cnt_q;      // header bytes still expected
   logic [39:0]         hdr_q;          // first five header bytes, shifted in
   logic [LEN_W-1:0]    rem_q;          // data bytes still to transfer
   logic [7:0]          csum_q;         // running data checksum
   logic                wr_pend_q;      // advance address after a write pulse
   logic                fetch_wait_q;   // first RFETCH cycle: BRAM latching addr

   logic                err_range_q;
   logic                err_chan_q;
   logic                err_abort_q;

   // Header fields as seen when the sixth byte arrives
   logic [LEN_W-1:0]    hdr_start_w;
   logic [LEN_W-1:0]    hdr_len_w;
   logic [SUM_W-1:0]    hdr_end_w;
   logic                hdr_range_bad_w;
   logic                chan_bad_w;

   // Decode header fields and range/channel checks
   assign hdr_start_w     = hdr_q[39:16];
   assign hdr_len_w       = {hdr_q[15:0], rx_byte};
   assign hdr_end_w       = SUM_W'(hdr_start_w) + SUM_W'(hdr_len_w);
   assign hdr_range_bad_w = (hdr_end_w > SUM_W'(MEM_DEPTH));
   assign chan_bad_w      = (CHK_W'(rx_byte[5:0]) >= CHK_W'(NUM_CH));

   // Drive outputs from their registers
   assign tx_byte   = tx_q;
   assign mem_addr  = addr_q;
   assign mem_ch    = ch_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;
   assign state     = state_q;

   // Transfer FSM with registered outputs, counters, checksum and error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         tx_q         <= 8'h00;
         addr_q       <= '0;
         ch_q         <= '0;
         we_q         <= 1'b0;
         wdata_q      <= 8'h00;
         is_write_q   <= 1'b0;
         hdr_cnt_q    <= 3'd0;
         hdr_q        <= 40'd0;
         rem_q        <= '0;
         csum_q       <= 8'h00;
         wr_pend_q    <= 1'b0;
         fetch_wait_q <= 1'b0;
         err_range_q  <= 1'b0;
         err_chan_q   <= 1'b0;
         err_abort_q  <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse unless re-armed below
         we_q <= 1'b0;

         // Address advances in the cycle the write pulse is on the bus
         if (wr_pend_q) begin
            addr_q    <= addr_q + ADDR_W'(1);
            wr_pend_q <= 1'b0;
         end

         if (cs_n && (state_q != ST_IDLE)) begin
            // Chip select released mid-command: drop everything, byte discarded
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            tx_q         <= 8'h00;
            err_abort_q  <= 1'b1;
            fetch_wait_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (byte_valid) begin
                     case (rx_byte[7:6])
                        OP_NOP: ;
                        OP_STATUS: begin
                           tx_q        <= {5'b00000, err_abort_q, err_chan_q, err_range_q};
                           err_abort_q <= 1'b0;
                           err_chan_q  <= 1'b0;
                           err_range_q <= 1'b0;
                        end
                        OP_WRITE, OP_READ: begin
                           if (chan_bad_w) begin
                              err_chan_q <= 1'b1;
                           end else begin
                              ch_q       <= CH_W'(rx_byte[5:0]);
                              is_write_q <= (rx_byte[7:6] == OP_WRITE);
                              csum_q     <= 8'h00;
                              hdr_cnt_q  <= 3'(HDR_BYTES);
                              state_q    <= ST_HDR;
                              busy_q     <= 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end

               ST_HDR: begin
                  if (byte_valid) begin
                     hdr_q     <= {hdr_q[31:0], rx_byte};
                     hdr_cnt_q <= hdr_cnt_q - 3'd1;
                     if (hdr_cnt_q == 3'd1) begin
                        if (hdr_range_bad_w) begin
                           err_range_q <= 1'b1;
                           state_q     <= ST_IDLE;
                           busy_q      <= 1'b0;
                        end else if (hdr_len_w == '0) begin
                           tx_q    <= 8'h00;
                           state_q <= ST_IDLE;
                           busy_q  <= 1'b0;
                        end else begin
                           addr_q <= hdr_start_w[ADDR_W-1:0];
                           rem_q  <= hdr_len_w;
                           if (is_write_q) begin
                              state_q <= ST_WDATA;
                           end else begin
                              state_q      <= ST_RFETCH;
                              fetch_wait_q <= 1'b1;
                           end
                        end
                     end
                  end
               end

               ST_WDATA: begin
                  if (byte_valid) begin
                     wdata_q   <= rx_byte;
                     we_q      <= 1'b1;
                     wr_pend_q <= 1'b1;
                     csum_q    <= csum_q + rx_byte;
                     rem_q     <= rem_q - LEN_W'(1);
                     if (rem_q == LEN_W'(1)) begin
                        tx_q    <= csum_q + rx_byte;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end

               ST_RFETCH: begin
                  // One cycle for the BRAM to register the address, then capture
                  if (fetch_wait_q) begin
                     fetch_wait_q <= 1'b0;
                  end else begin
                     tx_q    <= mem_rdata;
                     csum_q  <= csum_q + mem_rdata;
                     addr_q  <= addr_q + ADDR_W'(1);
                     state_q <= ST_RDATA;
                  end
               end

               ST_RDATA: begin
                  if (byte_valid) begin
                     rem_q <= rem_q - LEN_W'(1);
                     if (rem_q != LEN_W'(1)) begin
                        state_q      <= ST_RFETCH;
                        fetch_wait_q <= 1'b1;
                     end else begin
                        tx_q    <= csum_q;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_bram_xfer_ctrl.sv
// Directed bench for spi_bram_xfer_ctrl: byte-exchange vector table plus
// hand-written sequences for long transfers and asynchronous reset.
module tb_spi_bram_xfer_ctrl;

   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned CH_W      = 2;
   localparam int unsigned MEM_DEPTH = 76800;

   localparam logic [2:0] S_I = 3'd0;
   localparam logic [2:0] S_H = 3'd1;
   localparam logic [2:0] S_W = 3'd2;
   localparam logic [2:0] S_R = 3'd4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cs_n;
   logic              byte_valid;
   logic [7:0]        rx_byte;
   logic [7:0]        tx_byte;
   logic [ADDR_W-1:0] mem_addr;
   logic [CH_W-1:0]   mem_ch;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              busy;
   logic [2:0]        state;

   int checks = 0;
   int errors = 0;

   // BRAM model and write monitor
   logic [7:0] bram [NUM_CH][MEM_DEPTH];
   int wr_cnt = 0;
   int bad_addr = 0;
   int dbl_we = 0;
   logic we_prev = 1'b0;
   int wr_addr_log [0:15];
   int wr_ch_log   [0:15];

   spi_bram_xfer_ctrl #(
      .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .MEM_DEPTH(MEM_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .byte_valid(byte_valid),
      .rx_byte(rx_byte), .tx_byte(tx_byte), .mem_addr(mem_addr),
      .mem_ch(mem_ch), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      we_prev <= mem_we;
      if (mem_we) begin
         if (int'(mem_addr) < MEM_DEPTH) bram[mem_ch][mem_addr] <= mem_wdata;
         else bad_addr <= bad_addr + 1;
         if (we_prev) dbl_we <= dbl_we + 1;
         if (wr_cnt < 16) begin
            wr_addr_log[wr_cnt] <= int'(mem_addr);
            wr_ch_log[wr_cnt]   <= int'(mem_ch);
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (int'(mem_addr) < MEM_DEPTH) mem_rdata <= bram[mem_ch][mem_addr];
      else mem_rdata <= 8'h00;
   end

   typedef struct {
      logic       abort;
      logic [7:0] rx;
      logic [7:0] exp_tx;
      logic [2:0] exp_state;
      int         exp_wr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic ab, input logic [7:0] rx,
                               input logic [7:0] tx, input logic [2:0] st,
                               input int wr);
      vec_t v;
      v.abort = ab; v.rx = rx; v.exp_tx = tx; v.exp_state = st; v.exp_wr = wr;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One byte exchange, then let prefetch/write settle before sampling
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b; byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Chip select release coinciding with a byte pulse
   task automatic abort_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b; byte_valid = 1'b1; cs_n = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0; cs_n = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_tx"},    32'(tx_byte),   32'h0);
      check({tag, "_addr"},  32'(mem_addr),  32'h0);
      check({tag, "_ch"},    32'(mem_ch),    32'h0);
      check({tag, "_we"},    32'(mem_we),    32'h0);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
      check({tag, "_busy"},  32'(busy),      32'h0);
      check({tag, "_state"}, 32'(state),     32'h0);
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 3 + 1);
   endfunction

   initial begin
      logic [7:0] sum;
      int wr_base;

      rst = 1'b0; cs_n = 1'b1; byte_valid = 1'b0; rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);
      cs_n = 1'b0;
      @(negedge clk);

      // WRITE ch2 @0x10 len 4: 01 02 03 04
      add(0, 8'h42, 8'h00, S_H, 0);
      add(0, 8'h00, 8'h00, S_H, 0); add(0, 8'h00, 8'h00, S_H, 0); add(0, 8'h10, 8'h00, S_H, 0);
      add(0, 8'h00, 8'h00, S_H, 0); add(0, 8'h00, 8'h00, S_H, 0); add(0, 8'h04, 8'h00, S_W, 0);
      add(0, 8'h01, 8'h00, S_W, 1); add(0, 8'h02, 8'h00, S_W, 2);
      add(0, 8'h03, 8'h00, S_W, 3); add(0, 8'h04, 8'h0A, S_I, 4);
      // READ ch2 @0x10 len 4
      add(0, 8'h82, 8'h0A, S_H, 4);
      add(0, 8'h00, 8'h0A, S_H, 4); add(0, 8'h00, 8'h0A, S_H, 4); add(0, 8'h10, 8'h0A, S_H, 4);
      add(0, 8'h00, 8'h0A, S_H, 4); add(0, 8'h00, 8'h0A, S_H, 4); add(0, 8'h04, 8'h01, S_R, 4);
      add(0, 8'hFF, 8'h02, S_R, 4); add(0, 8'hFF, 8'h03, S_R, 4);
      add(0, 8'hFF, 8'h04, S_R, 4); add(0, 8'hFF, 8'h0A, S_I, 4);
      // NOP
      add(0, 8'h00, 8'h0A, S_I, 4);
      // WRITE ch0 @76798 len 3: out of range
      add(0, 8'h40, 8'h0A, S_H, 4);
      add(0, 8'h01, 8'h0A, S_H, 4); add(0, 8'h2B, 8'h0A, S_H, 4); add(0, 8'hFE, 8'h0A, S_H, 4);
      add(0, 8'h00, 8'h0A, S_H, 4); add(0, 8'h00, 8'h0A, S_H, 4); add(0, 8'h03, 8'h0A, S_I, 4);
      add(0, 8'hC0, 8'h01, S_I, 4); add(0, 8'hC0, 8'h00, S_I, 4);
      // WRITE ch3 @76797 len 3: ends exactly at MEM_DEPTH
      add(0, 8'h43, 8'h00, S_H, 4);
      add(0, 8'h01, 8'h00, S_H, 4); add(0, 8'h2B, 8'h00, S_H, 4); add(0, 8'hFD, 8'h00, S_H, 4);
      add(0, 8'h00, 8'h00, S_H, 4); add(0, 8'h00, 8'h00, S_H, 4); add(0, 8'h03, 8'h00, S_W, 4);
      add(0, 8'hAA, 8'h00, S_W, 5); add(0, 8'hBB, 8'h00, S_W, 6); add(0, 8'hCC, 8'h31, S_I, 7);
      // Bad channel, then STATUS
      add(0, 8'h45, 8'h31, S_I, 7); add(0, 8'hC0, 8'h02, S_I, 7);
      // WRITE ch1 len 0
      add(0, 8'h41, 8'h02, S_H, 7);
      add(0, 8'h00, 8'h02, S_H, 7); add(0, 8'h00, 8'h02, S_H, 7); add(0, 8'h00, 8'h02, S_H, 7);
      add(0, 8'h00, 8'h02, S_H, 7); add(0, 8'h00, 8'h02, S_H, 7); add(0, 8'h00, 8'h00, S_I, 7);
      // WRITE ch1 @0x20 len 8, aborted after 3 bytes (abort with a byte pulse)
      add(0, 8'h41, 8'h00, S_H, 7);
      add(0, 8'h00, 8'h00, S_H, 7); add(0, 8'h00, 8'h00, S_H, 7); add(0, 8'h20, 8'h00, S_H, 7);
      add(0, 8'h00, 8'h00, S_H, 7); add(0, 8'h00, 8'h00, S_H, 7); add(0, 8'h08, 8'h00, S_W, 7);
      add(0, 8'h11, 8'h00, S_W, 8); add(0, 8'h22, 8'h00, S_W, 9); add(0, 8'h33, 8'h00, S_W, 10);
      add(1, 8'h44, 8'h00, S_I, 10);
      add(0, 8'hC0, 8'h04, S_I, 10);
      // READ ch1 @0x20 len 3 after the abort
      add(0, 8'h81, 8'h04, S_H, 10);
      add(0, 8'h00, 8'h04, S_H, 10); add(0, 8'h00, 8'h04, S_H, 10); add(0, 8'h20, 8'h04, S_H, 10);
      add(0, 8'h00, 8'h04, S_H, 10); add(0, 8'h00, 8'h04, S_H, 10); add(0, 8'h03, 8'h11, S_R, 10);
      add(0, 8'hFF, 8'h22, S_R, 10); add(0, 8'hFF, 8'h33, S_R, 10); add(0, 8'hFF, 8'h66, S_I, 10);

      foreach (vecs[i]) begin
         if (vecs[i].abort) abort_byte(vecs[i].rx);
         else send_byte(vecs[i].rx);
         check($sformatf("v%0d_tx", i),    32'(tx_byte), 32'(vecs[i].exp_tx));
         check($sformatf("v%0d_state", i), 32'(state),   32'(vecs[i].exp_state));
         check($sformatf("v%0d_busy", i),  32'(busy),    32'(vecs[i].exp_state != S_I));
         check($sformatf("v%0d_wrcnt", i), 32'(wr_cnt),  32'(vecs[i].exp_wr));
      end

      // Write addresses and channels seen on the bus
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wlog%0d_addr", i), 32'(wr_addr_log[i]), 32'(32'h10 + i));
         check($sformatf("wlog%0d_ch", i),   32'(wr_ch_log[i]),   32'd2);
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wlog%0d_addr", i + 4), 32'(wr_addr_log[i + 4]), 32'(76797 + i));
         check($sformatf("wlog%0d_ch", i + 4),   32'(wr_ch_log[i + 4]),   32'd3);
         check($sformatf("wlog%0d_addr", i + 7), 32'(wr_addr_log[i + 7]), 32'(32'h20 + i));
         check($sformatf("wlog%0d_ch", i + 7),   32'(wr_ch_log[i + 7]),   32'd1);
      end

      // Long WRITE ch0 @0x100 len 100
      wr_base = wr_cnt;
      sum = 8'h00;
      send_byte(8'h40);
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h64);
      for (int i = 0; i < 100; i++) begin
         send_byte(pat(i));
         sum = sum + pat(i);
      end
      check("long_wr_csum",  32'(tx_byte), 32'(sum));
      check("long_wr_state", 32'(state), 32'(S_I));
      check("long_wr_cnt",   32'(wr_cnt - wr_base), 32'd100);

      // READ ch0 @0x100 len 100, reset in the middle of RDATA
      send_byte(8'h80);
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h64);
      check("lrd_tx0", 32'(tx_byte), 32'(pat(0)));
      for (int i = 1; i < 5; i++) begin
         send_byte(8'h00);
         check($sformatf("lrd_tx%0d", i), 32'(tx_byte), 32'(pat(i)));
      end
      check("lrd_state", 32'(state), 32'(S_R));
      #2 rst = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_byte(8'hC0);
      check("post_rst_status", 32'(tx_byte), 32'h0);

      // New READ ch0 @0x110 len 3 after reset
      send_byte(8'h80);
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h10);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
      sum = 8'h00;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rrd_tx%0d", i), 32'(tx_byte), 32'(pat(16 + i)));
         sum = sum + pat(16 + i);
         send_byte(8'h00);
      end
      check("rrd_csum",  32'(tx_byte), 32'(sum));
      check("rrd_state", 32'(state), 32'(S_I));

      // Reset while the write strobe is high drops it without a clock edge
      wr_base = wr_cnt;
      send_byte(8'h41);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
      @(negedge clk);
      rx_byte = 8'h99; byte_valid = 1'b1;
      @(posedge clk);
      #1 check("we_before_rst", 32'(mem_we), 32'h1);
      rst = 1'b0;
      #1 check("we_after_rst", 32'(mem_we), 32'h0);
      check("state_after_rst", 32'(state), 32'(S_I));
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_we_nowrite", 32'(wr_cnt - wr_base), 32'd0);

      check("no_out_of_range_write", 32'(bad_addr), 32'd0);
      check("we_single_cycle",       32'(dbl_we),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
